// File: rtl/pmem_frame_pkg.sv
// Shared timing defaults, encodings and object-word layout for the frame controller.
package pmem_frame_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned OBJ_W     = 32;
  localparam int unsigned NUM_SLOTS = 3;

  // Packed object word: {rgb[31:20], y[19:10], x[9:0]}
  localparam int unsigned OBJ_X_LSB   = 0;
  localparam int unsigned OBJ_Y_LSB   = 10;
  localparam int unsigned OBJ_RGB_LSB = 20;

  typedef enum logic [1:0] {
    SelBall = 2'd0,
    SelBarL = 2'd1,
    SelBarR = 2'd2,
    SelRsvd = 2'd3
  } upd_sel_e;

  typedef enum logic [1:0] {
    StVAct   = 2'd0,
    StVFront = 2'd1,
    StVSync  = 2'd2,
    StVBack  = 2'd3
  } vstate_e;

  function automatic logic [OBJ_W-1:0] obj_pack(input logic [11:0] rgb, input logic [9:0] y,
                                                input logic [9:0] x);
    return {rgb, y, x};
  endfunction

endpackage

// File: rtl/pmem_frame_cnt.sv
// Modulo-MAX_VAL counter with enable; o_wrap flags the enabled cycle that returns to zero.
module pmem_frame_cnt #(
  parameter int unsigned MAX_VAL = 800,
  parameter int unsigned W       = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == W'(MAX_VAL - 1));
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pmem_frame_ctrl.sv
// Video timing generator with frame-synchronous object updates.
// Define PMEM_FRAME_LATCH_EN to latch updates until the active->front-porch commit.
module pmem_frame_ctrl
  import pmem_frame_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [1:0]       upd_sel,
  input  logic [OBJ_W-1:0] upd_data,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic [OBJ_W-1:0] ball_loc,
  output logic [OBJ_W-1:0] barl_loc,
  output logic [OBJ_W-1:0] barr_loc,
  output logic             vblank_pulse,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;

  logic [CNT_W-1:0] w_hcnt, w_vcnt;
  logic             w_hwrap, w_vwrap, w_commit;
  vstate_e          r_state;

  logic [CNT_W-1:0] r_pixel_x, r_pixel_y;
  logic             r_video_on, r_hsync, r_vsync, r_vblank_pulse;
  logic [15:0]      r_frame_cnt;
  logic [OBJ_W-1:0] r_live [NUM_SLOTS];

  pmem_frame_cnt #(.MAX_VAL(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (pix_en),
    .o_cnt  (w_hcnt),
    .o_wrap (w_hwrap)
  );

  pmem_frame_cnt #(.MAX_VAL(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_hwrap),
    .o_cnt  (w_vcnt),
    .o_wrap (w_vwrap)
  );

  // Commit fires on the line wrap that leaves the last visible line.
  assign w_commit = w_hwrap && (r_state == StVAct) && (w_vcnt == CNT_W'(V_ACTIVE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StVAct;
      r_pixel_x      <= '0;
      r_pixel_y      <= '0;
      r_video_on     <= 1'b0;
      r_hsync        <= 1'b1;
      r_vsync        <= 1'b1;
      r_vblank_pulse <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      r_pixel_x      <= w_hcnt;
      r_pixel_y      <= w_vcnt;
      r_video_on     <= (w_hcnt < CNT_W'(H_ACTIVE)) && (r_state == StVAct);
      r_hsync        <= !((w_hcnt >= CNT_W'(HS_BEG)) && (w_hcnt < CNT_W'(HS_END)));
      r_vsync        <= (r_state != StVSync);
      r_vblank_pulse <= w_commit;
      if (w_commit) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_hwrap) begin
        unique case (r_state)
          StVAct:   if (w_vcnt == CNT_W'(V_ACTIVE - 1)) r_state <= StVFront;
          StVFront: if (w_vcnt == CNT_W'(V_ACTIVE + V_FP - 1)) r_state <= StVSync;
          StVSync:  if (w_vcnt == CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1)) r_state <= StVBack;
          StVBack:  if (w_vwrap) r_state <= StVAct;
        endcase
      end
    end
  end

`ifdef PMEM_FRAME_LATCH_EN
  logic [OBJ_W-1:0]     r_pend [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_dirty, w_dirty_d, w_wr;
  logic                 r_upd_ready;

  // A write accepted on the commit edge lands in the next frame's pending set.
  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_wr[i] = upd_valid && r_upd_ready && (upd_sel == 2'(i));
    end
    w_dirty_d = (w_commit ? '0 : r_dirty) | w_wr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_ready <= 1'b1;
      r_dirty     <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_pend[i] <= '0;
        r_live[i] <= '0;
      end
    end else begin
      r_upd_ready <= !w_commit;
      r_dirty     <= w_dirty_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_wr[i]) r_pend[i] <= upd_data;
        if (w_commit && r_dirty[i]) r_live[i] <= r_pend[i];
      end
    end
  end

  assign upd_ready = r_upd_ready;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_live[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (upd_valid && (upd_sel == 2'(i))) r_live[i] <= upd_data;
      end
    end
  end

  assign upd_ready = 1'b1;
`endif

  assign pixel_x      = r_pixel_x;
  assign pixel_y      = r_pixel_y;
  assign video_on     = r_video_on;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign vblank_pulse = r_vblank_pulse;
  assign frame_cnt    = r_frame_cnt;
  assign ball_loc     = r_live[SelBall];
  assign barl_loc     = r_live[SelBarL];
  assign barr_loc     = r_live[SelBarR];

endmodule

// File: tb/tb_pmem_frame_ctrl.sv
// Self-checking bench for pmem_frame_ctrl: reduced timing, per-cycle model compare
// plus directed literal checks; follows PMEM_FRAME_LATCH_EN like the design.
module tb_pmem_frame_ctrl;
  import pmem_frame_pkg::*;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk, rst, pix_en, upd_valid, upd_ready;
  logic [1:0]  upd_sel;
  logic [31:0] upd_data;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync, vsync, vblank_pulse;
  logic [31:0] ball_loc, barl_loc, barr_loc;
  logic [15:0] frame_cnt;

  pmem_frame_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_en       (pix_en),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_sel      (upd_sel),
    .upd_data     (upd_data),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .video_on     (video_on),
    .hsync        (hsync),
    .vsync        (vsync),
    .ball_loc     (ball_loc),
    .barl_loc     (barl_loc),
    .barr_loc     (barr_loc),
    .vblank_pulse (vblank_pulse),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counters as plain integers, outputs from range rules.
  int          mh, mv, e_px, e_py, m_frame;
  bit          e_von, e_hs, e_vs, e_pulse, m_ready;
  logic [31:0] m_live [3];
  logic [31:0] m_pend [3];
  bit          m_dirty [3];

  task automatic model_step();
    bit commit;
    if (rst) begin
      mh = 0; mv = 0; e_px = 0; e_py = 0; e_von = 0; e_hs = 1; e_vs = 1; e_pulse = 0;
      m_frame = 0; m_ready = 1;
      for (int i = 0; i < 3; i++) begin m_live[i] = 0; m_pend[i] = 0; m_dirty[i] = 0; end
    end else begin
      commit = pix_en && (mh == HT - 1) && (mv == VA - 1);
      e_px  = mh;
      e_py  = mv;
      e_von = (mh < HA) && (mv < VA);
      e_hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
      e_vs  = !((mv >= VA + VF) && (mv < VA + VF + VS));
`ifdef PMEM_FRAME_LATCH_EN
      if (commit) begin
        for (int i = 0; i < 3; i++) begin
          if (m_dirty[i]) m_live[i] = m_pend[i];
          m_dirty[i] = 0;
        end
      end
      if (upd_valid && m_ready && upd_sel != 2'd3) begin
        m_pend[upd_sel] = upd_data;
        m_dirty[upd_sel] = 1;
      end
      m_ready = !commit;
`else
      if (upd_valid && upd_sel != 2'd3) m_live[upd_sel] = upd_data;
`endif
      e_pulse = commit;
      if (commit) m_frame = (m_frame + 1) % 65536;
      if (pix_en) begin
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("pixel_x", 32'(pixel_x), 32'(e_px));
      chk("pixel_y", 32'(pixel_y), 32'(e_py));
      chk("video_on", 32'(video_on), 32'(e_von));
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("vblank_pulse", 32'(vblank_pulse), 32'(e_pulse));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
      chk("upd_ready", 32'(upd_ready), 32'(m_ready));
      chk("ball_loc", ball_loc, m_live[0]);
      chk("barl_loc", barl_loc, m_live[1]);
      chk("barr_loc", barr_loc, m_live[2]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic upd(input logic [1:0] sel, input logic [31:0] data, output int waits);
    bit ok, rdy;
    ok = 0; waits = 0;
    upd_sel = sel; upd_data = data; upd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rdy = upd_ready;
      @(negedge clk);
      if (rdy) begin ok = 1; break; end
      waits++;
    end
    upd_valid = 1'b0;
    chk("upd_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_pos(input int x, input int y);
    bit ok = 0;
    for (int k = 0; k < 2 * HT * VT; k++) begin
      if (pixel_x == 10'(x) && pixel_y == 10'(y)) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("reach_pos", 32'(ok), 32'd1);
  endtask

  task automatic wait_pulse();
    bit ok = 0;
    for (int k = 0; k < 2 * HT * VT; k++) begin
      @(negedge clk);
      if (vblank_pulse) begin ok = 1; break; end
    end
    chk("see_vblank_pulse", 32'(ok), 32'd1);
  endtask

  int hl, vl, w;
  bit hs_seen;

  initial begin
    rst = 1'b1; pix_en = 1'b0; upd_valid = 1'b0; upd_sel = 2'd0; upd_data = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("lit_rst_px", 32'(pixel_x), 32'd0);
    chk("lit_rst_hsync", 32'(hsync), 32'd1);
    chk("lit_rst_vsync", 32'(vsync), 32'd1);
    chk("lit_rst_video_on", 32'(video_on), 32'd0);
    chk("lit_rst_ready", 32'(upd_ready), 32'd1);
    chk("lit_rst_frame", 32'(frame_cnt), 32'd0);

    // One full frame of ticks
    rst = 1'b0; pix_en = 1'b1;
    hl = 0; vl = 0; hs_seen = 0;
    for (int k = 0; k < HT * VT; k++) begin
      @(negedge clk);
      if (!hsync) hl++;
      if (!vsync) vl++;
      if (!hsync && !hs_seen) begin
        hs_seen = 1;
        chk("lit_hsync_start_x", 32'(pixel_x), 32'd18);
      end
      if (!vsync && vl == 1) chk("lit_vsync_start_y", 32'(pixel_y), 32'd14);
    end
    chk("lit_hsync_low_ticks", 32'(hl), 32'd76);
    chk("lit_vsync_low_ticks", 32'(vl), 32'd50);
    chk("lit_frame_after_one", 32'(frame_cnt), 32'd1);

    // Gapped pixel enable, with an update while frozen
    for (int k = 0; k < 30; k++) begin
      pix_en = (k % 3) != 0;
      @(negedge clk);
    end
    pix_en = 1'b0;
    upd(2'd2, 32'h0000_0ABC, w);
    repeat (5) @(negedge clk);
    pix_en = 1'b1;

`ifdef PMEM_FRAME_LATCH_EN
    wait_pos(0, 5);
    upd(2'd0, obj_pack(12'hFFF, 10'd40, 10'd160), w);
    chk("lit_ball_before_commit", ball_loc, 32'h0);
    wait_pulse();
    chk("lit_ball_after_commit", ball_loc, 32'hFFF0_A0A0);
    chk("lit_commit_px", 32'(pixel_x), 32'd24);
    chk("lit_commit_py", 32'(pixel_y), 32'd11);
    chk("lit_frame_2", 32'(frame_cnt), 32'd2);
    chk("lit_barr_abc", barr_loc, 32'h0000_0ABC);
    @(negedge clk);
    chk("lit_pulse_one_clk", 32'(vblank_pulse), 32'd0);

    upd(2'd2, 32'h1, w);
    upd(2'd2, 32'h2, w);
    wait_pulse();
    chk("lit_barr_last_wins", barr_loc, 32'h2);
    chk("lit_barl_untouched", barl_loc, 32'h0);
    chk("lit_ready_low_commit", 32'(upd_ready), 32'd0);
    upd(2'd0, 32'h1234_5678, w);
    chk("lit_held_wait_one", 32'(w), 32'd1);
    chk("lit_ready_back", 32'(upd_ready), 32'd1);
    chk("lit_ball_not_yet", ball_loc, 32'hFFF0_A0A0);
    wait_pulse();
    chk("lit_ball_next_commit", ball_loc, 32'h1234_5678);
    chk("lit_frame_4", 32'(frame_cnt), 32'd4);

    wait_pos(0, 3);
    upd(2'd1, 32'hDEAD_BEEF, w);
    wait_pos(0, 7);
`else
    upd(2'd1, obj_pack(12'h003, 10'd3, 10'd5), w);
    chk("lit_barl_direct", barl_loc, 32'h0030_0C05);
    chk("lit_no_wait", 32'(w), 32'd0);
    upd(2'd3, 32'hAAAA_AAAA, w);
    chk("lit_rsvd_ball", ball_loc, 32'h0);
    chk("lit_rsvd_barl", barl_loc, 32'h0030_0C05);
    chk("lit_rsvd_barr", barr_loc, 32'h0000_0ABC);
    wait_pulse();
    chk("lit_ready_const", 32'(upd_ready), 32'd1);
    chk("lit_frame_2", 32'(frame_cnt), 32'd2);
    wait_pos(0, 7);
`endif

    // Reset mid-frame
    rst = 1'b1;
    @(negedge clk);
    chk("lit_mrst_px", 32'(pixel_x), 32'd0);
    chk("lit_mrst_ball", ball_loc, 32'h0);
    chk("lit_mrst_barl", barl_loc, 32'h0);
    chk("lit_mrst_barr", barr_loc, 32'h0);
    chk("lit_mrst_frame", 32'(frame_cnt), 32'd0);
    chk("lit_mrst_ready", 32'(upd_ready), 32'd1);
    rst = 1'b0;
    wait_pulse();
    chk("lit_post_rst_barl", barl_loc, 32'h0);
    chk("lit_post_rst_frame", 32'(frame_cnt), 32'd1);
    chk("lit_post_rst_py", 32'(pixel_y), 32'd11);

    repeat (50) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
